// File: rtl/pipe_ctrl.sv
// Pipeline hazard and run controller for a five-stage pipeline.
// Issues stage register load enables and bubble (flush) requests for
// memory stalls, taken branches and load-use hazards. Also sequences
// IDLE -> RUN -> DRAIN -> IDLE and stops in HALT on a memory watchdog timeout.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall cycle
// counter. Without it, stall_cnt_o is tied to zero and no counter register exists.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 run request (1 = execute, 0 = drain and idle)
//   IDEX_MemRead_i          load in EX
//   IDEX_RTaddr_i           load destination in EX
//   IFID_RSaddr_i/RTaddr_i  sources of the instruction in ID
//   EXMEM_BranchTaken_i     taken branch resolved in MEM
//   EXMEM_MemReq_i          data memory access in MEM
//   mem_ack_i               data memory completes this cycle
//   *Write_o                stage register load enables (combinational)
//   *Flush_o                load a bubble into the stage (combinational)
//   mem_req_o               data memory request strobe (combinational)
//   state_o                 IDLE=0 RUN=1 MEMWAIT=2 DRAIN=3 HALT=4
//   err_o                   sticky watchdog timeout flag
//   stall_cnt_o             stall cycle counter
module pipe_ctrl #(
  parameter int unsigned WDOG_CYCLES  = 255,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_RTaddr_i,
  input  logic [4:0]  IFID_RSaddr_i,
  input  logic [4:0]  IFID_RTaddr_i,
  input  logic        EXMEM_BranchTaken_i,
  input  logic        EXMEM_MemReq_i,
  input  logic        mem_ack_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IDEXWrite_o,
  output logic        EXMEMWrite_o,
  output logic        IFIDFlush_o,
  output logic        IDEXFlush_o,
  output logic        EXMEMFlush_o,
  output logic        MEMWBFlush_o,
  output logic        mem_req_o,
  output logic [2:0]  state_o,
  output logic        err_o,
  output logic [15:0] stall_cnt_o
);

  localparam int unsigned WCNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam int unsigned DCNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_MEMWAIT = 3'd2,
    S_DRAIN   = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  state_t              r_ret_state, w_ret_nxt;
  state_t              w_eff;
  logic [WCNT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic [DCNT_W-1:0]   r_drain_cnt, w_drain_nxt;
  logic                r_err, w_err_nxt;
  logic                w_mem_stall;
  logic                w_lu_hazard;
  logic                w_lu_stall;
  logic                w_active;
  logic                w_stall;

  // Hazard detection
  assign w_mem_stall = EXMEM_MemReq_i & ~mem_ack_i;
  assign w_lu_hazard = IDEX_MemRead_i && (IDEX_RTaddr_i != 5'd0) &&
                       ((IDEX_RTaddr_i == IFID_RSaddr_i) || (IDEX_RTaddr_i == IFID_RTaddr_i));

  // State and counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ret_state <= S_RUN;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next state and stage controls; defaults are the freeze pattern
  always_comb begin
    PCWrite_o    = 1'b0;
    IFIDWrite_o  = 1'b0;
    IDEXWrite_o  = 1'b0;
    EXMEMWrite_o = 1'b0;
    IFIDFlush_o  = 1'b0;
    IDEXFlush_o  = 1'b0;
    EXMEMFlush_o = 1'b0;
    MEMWBFlush_o = 1'b1;
    mem_req_o    = 1'b0;
    w_state_nxt  = r_state;
    w_ret_nxt    = r_ret_state;
    w_wait_nxt   = r_wait_cnt;
    w_drain_nxt  = r_drain_cnt;
    w_err_nxt    = r_err;
    w_eff        = r_state;
    w_active     = 1'b0;
    w_lu_stall   = 1'b0;
    w_stall      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_nxt = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        w_active = 1'b1;
      end
      S_MEMWAIT: begin
        mem_req_o = EXMEM_MemReq_i;
        if (mem_ack_i) begin
          // Ack cycle behaves as the return state but always resumes it
          w_active    = 1'b1;
          w_eff       = r_ret_state;
          w_state_nxt = r_ret_state;
        end else begin
          w_stall = 1'b1;
          if (r_wait_cnt == WCNT_W'(WDOG_CYCLES - 1)) begin
            w_state_nxt = S_HALT;
            w_err_nxt   = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + WCNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (w_active) begin
      mem_req_o = EXMEM_MemReq_i;
      if (w_mem_stall) begin
        w_stall     = 1'b1;
        w_state_nxt = S_MEMWAIT;
        w_ret_nxt   = w_eff;
        w_wait_nxt  = '0;
      end else begin
        PCWrite_o    = 1'b1;
        IFIDWrite_o  = 1'b1;
        IDEXWrite_o  = 1'b1;
        EXMEMWrite_o = 1'b1;
        MEMWBFlush_o = 1'b0;
        if (EXMEM_BranchTaken_i) begin
          IFIDFlush_o  = 1'b1;
          IDEXFlush_o  = 1'b1;
          EXMEMFlush_o = 1'b1;
        end else if (w_lu_hazard) begin
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          IDEXFlush_o = 1'b1;
          w_lu_stall  = 1'b1;
          w_stall     = 1'b1;
        end
        // Draining: stop fetching and feed bubbles into ID
        if (w_eff == S_DRAIN) begin
          PCWrite_o   = 1'b0;
          IFIDFlush_o = 1'b1;
        end
        // Sequencing uses the real state, so a MEMWAIT ack cycle neither drains nor samples start
        if (r_state == S_RUN && !start_i) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = DCNT_W'(DRAIN_CYCLES);
        end else if (r_state == S_DRAIN && !w_lu_stall) begin
          if (r_drain_cnt <= DCNT_W'(1)) begin
            w_drain_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_drain_nxt = r_drain_cnt - DCNT_W'(1);
          end
        end
      end
    end
  end

  assign state_o = r_state;
  assign err_o   = r_err;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of stall-induced PC hold cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  logic w_unused_stall;
  assign w_unused_stall = w_stall;
  assign stall_cnt_o    = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; expected controls are queued per step and compared mid-cycle.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        memrd = 1'b0;
  logic [4:0]  idex_rt = 5'd0;
  logic [4:0]  ifid_rs = 5'd0;
  logic [4:0]  ifid_rt = 5'd0;
  logic        br = 1'b0;
  logic        mreq = 1'b0;
  logic        ack = 1'b0;
  logic        pcw, ifidw, idexw, exmemw, ifidf, idexf, exmemf, memwbf, mreq_o, err;
  logic [2:0]  st;
  logic [15:0] sc;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_sc = 16'd0;

  typedef struct {
    string       tag;
    logic [12:0] ctl;
    logic [15:0] sc;
    bit          stall;
  } exp_t;
  exp_t q[$];

  pipe_ctrl #(.WDOG_CYCLES(8), .DRAIN_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .IDEX_MemRead_i(memrd), .IDEX_RTaddr_i(idex_rt),
    .IFID_RSaddr_i(ifid_rs), .IFID_RTaddr_i(ifid_rt),
    .EXMEM_BranchTaken_i(br), .EXMEM_MemReq_i(mreq), .mem_ack_i(ack),
    .PCWrite_o(pcw), .IFIDWrite_o(ifidw), .IDEXWrite_o(idexw), .EXMEMWrite_o(exmemw),
    .IFIDFlush_o(ifidf), .IDEXFlush_o(idexf), .EXMEMFlush_o(exmemf), .MEMWBFlush_o(memwbf),
    .mem_req_o(mreq_o), .state_o(st), .err_o(err), .stall_cnt_o(sc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  // {writes PC/IFID/IDEX/EXMEM, flushes IFID/IDEX/EXMEM/MEMWB, mem_req, state, err}
  function automatic logic [12:0] mk(input logic [3:0] w, input logic [3:0] f,
                                     input logic mr, input logic [2:0] s, input logic e);
    return {w, f, mr, s, e};
  endfunction

  localparam logic [3:0] W_FRZ = 4'b0000, F_FRZ = 4'b0001;
  localparam logic [3:0] W_RUN = 4'b1111, F_RUN = 4'b0000;
  localparam logic [3:0] W_LU  = 4'b0011, F_LU  = 4'b0100;
  localparam logic [3:0] F_BR  = 4'b1110;
  localparam logic [3:0] W_DR  = 4'b0111, F_DR  = 4'b1000;
  localparam logic [3:0] W_DLU = 4'b0011, F_DLU = 4'b1100;

  task automatic clr_in();
    memrd = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    br = 1'b0; mreq = 1'b0; ack = 1'b0;
  endtask

  // Push expectation for the current inputs, compare mid-cycle, advance one clock
  task automatic step(input string tag, input logic [12:0] ctl, input bit stall);
    exp_t e;
    exp_t g;
    logic [12:0] obs;
    e.tag = tag; e.ctl = ctl; e.sc = exp_sc; e.stall = stall;
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    obs = {pcw, ifidw, idexw, exmemw, ifidf, idexf, exmemf, memwbf, mreq_o, st, err};
    checks++;
    assert (obs === g.ctl) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", g.tag, obs, g.ctl);
    end
    checks++;
    assert (sc === g.sc) else begin
      failures++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", g.tag, sc, g.sc);
    end
    if (g.stall && PERF) exp_sc = exp_sc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_in();
    start = 1'b1;
    @(posedge clk); #1;
    step("reset_hold", mk(W_FRZ, F_FRZ, 1'b0, 3'd0, 1'b0), 1'b0);
    rst = 1'b0;
    step("idle_start", mk(W_FRZ, F_FRZ, 1'b0, 3'd0, 1'b0), 1'b0);
    step("run", mk(W_RUN, F_RUN, 1'b0, 3'd1, 1'b0), 1'b0);

    memrd = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    step("lu_rs", mk(W_LU, F_LU, 1'b0, 3'd1, 1'b0), 1'b1);
    idex_rt = 5'd0; ifid_rs = 5'd0;
    step("lu_r0", mk(W_RUN, F_RUN, 1'b0, 3'd1, 1'b0), 1'b0);
    idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
    step("lu_rt", mk(W_LU, F_LU, 1'b0, 3'd1, 1'b0), 1'b1);
    br = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    step("br_wins", mk(W_RUN, F_BR, 1'b0, 3'd1, 1'b0), 1'b0);
    clr_in();

    mreq = 1'b1; ack = 1'b1;
    step("mem_same_ack", mk(W_RUN, F_RUN, 1'b1, 3'd1, 1'b0), 1'b0);
    ack = 1'b0;
    step("mem_stall1", mk(W_FRZ, F_FRZ, 1'b1, 3'd1, 1'b0), 1'b1);
    step("mem_wait2", mk(W_FRZ, F_FRZ, 1'b1, 3'd2, 1'b0), 1'b1);
    step("mem_wait3", mk(W_FRZ, F_FRZ, 1'b1, 3'd2, 1'b0), 1'b1);
    ack = 1'b1;
    step("mem_ack", mk(W_RUN, F_RUN, 1'b1, 3'd2, 1'b0), 1'b0);
    clr_in();
    step("mem_back_run", mk(W_RUN, F_RUN, 1'b0, 3'd1, 1'b0), 1'b0);

    // Drain with one memory stall and one load-use stall; start ignored while draining
    start = 1'b0;
    step("run_stop", mk(W_RUN, F_RUN, 1'b0, 3'd1, 1'b0), 1'b0);
    start = 1'b1; mreq = 1'b1;
    step("drain_mstall", mk(W_FRZ, F_FRZ, 1'b1, 3'd3, 1'b0), 1'b1);
    ack = 1'b1;
    step("drain_wait_ack", mk(W_DR, F_DR, 1'b1, 3'd2, 1'b0), 1'b0);
    clr_in();
    step("drain_a1", mk(W_DR, F_DR, 1'b0, 3'd3, 1'b0), 1'b0);
    memrd = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9;
    step("drain_lu", mk(W_DLU, F_DLU, 1'b0, 3'd3, 1'b0), 1'b1);
    clr_in();
    step("drain_a2", mk(W_DR, F_DR, 1'b0, 3'd3, 1'b0), 1'b0);
    step("drain_a3", mk(W_DR, F_DR, 1'b0, 3'd3, 1'b0), 1'b0);
    start = 1'b0;
    step("drain_a4", mk(W_DR, F_DR, 1'b0, 3'd3, 1'b0), 1'b0);
    step("idle_again", mk(W_FRZ, F_FRZ, 1'b0, 3'd0, 1'b0), 1'b0);
    start = 1'b1;
    step("idle_start2", mk(W_FRZ, F_FRZ, 1'b0, 3'd0, 1'b0), 1'b0);
    step("run2", mk(W_RUN, F_RUN, 1'b0, 3'd1, 1'b0), 1'b0);

    // Watchdog: eight unacknowledged MEMWAIT cycles, then HALT
    mreq = 1'b1;
    step("wd_stall", mk(W_FRZ, F_FRZ, 1'b1, 3'd1, 1'b0), 1'b1);
    for (int i = 0; i < 8; i++) begin
      step($sformatf("wd_wait%0d", i), mk(W_FRZ, F_FRZ, 1'b1, 3'd2, 1'b0), 1'b1);
    end
    step("halt", mk(W_FRZ, F_FRZ, 1'b0, 3'd4, 1'b1), 1'b0);
    ack = 1'b1; start = 1'b0;
    step("halt_sticky", mk(W_FRZ, F_FRZ, 1'b0, 3'd4, 1'b1), 1'b0);
    start = 1'b1;
    step("halt_sticky2", mk(W_FRZ, F_FRZ, 1'b0, 3'd4, 1'b1), 1'b0);

    rst = 1'b1; exp_sc = 16'd0;
    step("rst_halt", mk(W_FRZ, F_FRZ, 1'b0, 3'd0, 1'b0), 1'b0);
    rst = 1'b0; clr_in();
    step("idle_start3", mk(W_FRZ, F_FRZ, 1'b0, 3'd0, 1'b0), 1'b0);
    mreq = 1'b1;
    step("rst_mw_stall", mk(W_FRZ, F_FRZ, 1'b1, 3'd1, 1'b0), 1'b1);
    step("rst_mw_wait", mk(W_FRZ, F_FRZ, 1'b1, 3'd2, 1'b0), 1'b1);
    // Reset mid-MEMWAIT with ack pending; reset must win
    rst = 1'b1; ack = 1'b1; exp_sc = 16'd0;
    step("rst_mid_wait", mk(W_FRZ, F_FRZ, 1'b0, 3'd0, 1'b0), 1'b0);
    rst = 1'b0; clr_in();
    step("idle_start4", mk(W_FRZ, F_FRZ, 1'b0, 3'd0, 1'b0), 1'b0);
    step("run4", mk(W_RUN, F_RUN, 1'b0, 3'd1, 1'b0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WDOG_CYCLES, default 255, SHALL set the maximum number of MEMWAIT cycles tolerated before a fatal timeout.
REQ-002 Parameter DRAIN_CYCLES, default 4, SHALL set the number of advancing cycles spent in DRAIN.
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  SHALL be the reset, asynchronous and active-high.
REQ-005 start_i  in  1  run request; high = execute, low = drain and idle.
REQ-006 IDEX_MemRead_i  in  1  load is in EX.
REQ-007 IDEX_RTaddr_i  in  5  destination of the load in EX.
REQ-008 IFID_RSaddr_i, IFID_RTaddr_i  in  5 each  source registers of the instruction in ID.
REQ-009 EXMEM_BranchTaken_i  in  1  branch in MEM resolved taken (Branch AND zero).
REQ-010 EXMEM_MemReq_i  in  1  MemRead or MemWrite active in MEM.
REQ-011 mem_ack_i  in  1  data memory completes the access this cycle.
REQ-012 PCWrite_o, IFIDWrite_o, IDEXWrite_o, EXMEMWrite_o  out  1 each  stage register load enables.
REQ-013 IFIDFlush_o, IDEXFlush_o, EXMEMFlush_o, MEMWBFlush_o  out  1 each  load a bubble (all zero) instead of stage input.
REQ-014 mem_req_o  out  1  data memory request strobe.
REQ-015 state_o  out  3  current state: IDLE=0, RUN=1, MEMWAIT=2, DRAIN=3, HALT=4.
REQ-016 err_o  out  1  sticky watchdog timeout flag.
REQ-017 stall_cnt_o  out  16  stall cycle counter (see Configuration).

Function
REQ-018 Stage-control outputs SHALL be combinational from state and inputs; state, counters and err_o SHALL be registered.
REQ-019 Freeze is defined as: all Write enables 0, all Flush 0 except MEMWBFlush_o=1.
REQ-020 IDLE SHALL drive freeze; start_i=1 SHALL move to RUN next cycle.
REQ-021 RUN default SHALL be all Write enables 1, all Flush 0.
REQ-022 mem_req_o SHALL equal EXMEM_MemReq_i in RUN, MEMWAIT and DRAIN, else 0.
REQ-023 RUN/DRAIN priority per cycle SHALL be: memory stall > branch flush > load-use stall.
REQ-024 Memory stall (EXMEM_MemReq_i=1, mem_ack_i=0) SHALL drive freeze this cycle and enter MEMWAIT next cycle, saving the return state (RUN or DRAIN); ack in the same cycle SHALL cause no stall.
REQ-025 MEMWAIT SHALL drive freeze while mem_ack_i=0; on the ack cycle outputs SHALL be evaluated as in the return state and the next state SHALL be the return state.
REQ-026 Wait counter SHALL clear on MEMWAIT entry and increment each MEMWAIT cycle without ack; with no ack, WDOG_CYCLES MEMWAIT cycles SHALL be followed by HALT with err_o=1.
REQ-027 Branch flush SHALL assert IFIDFlush_o, IDEXFlush_o, EXMEMFlush_o with Write enables 1.
REQ-028 Load-use stall (IDEX_MemRead_i=1, IDEX_RTaddr_i!=0, IDEX_RTaddr_i equals IFID_RSaddr_i or IFID_RTaddr_i) SHALL drive PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1.
REQ-029 start_i sampled 0 in RUN SHALL enter DRAIN with drain counter = DRAIN_CYCLES; start_i SHALL be ignored outside RUN and IDLE.
REQ-030 DRAIN SHALL drive PCWrite_o=0 and IFIDFlush_o=1 on top of RUN rules; counter SHALL decrement only on cycles with no memory or load-use stall; on reaching 0 the next state SHALL be IDLE.
REQ-031 HALT SHALL drive freeze, mem_req_o=0, and SHALL be left only by reset.

Reset
REQ-032 rst_i=1 SHALL immediately force state IDLE, counters 0, err_o 0, saved return state RUN; reset SHALL win over any simultaneous input, including mid-MEMWAIT or mid-DRAIN.
REQ-033 During and after reset, outputs SHALL equal IDLE freeze values, stall_cnt_o=0.

Configuration
REQ-034 Macro PIPE_CTRL_PERF_EN defined: stall_cnt_o SHALL increment on each RUN, MEMWAIT or DRAIN cycle with PCWrite_o=0 caused by a stall, saturating at 16'hFFFF.
REQ-035 Macro PIPE_CTRL_PERF_EN undefined: stall_cnt_o SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-036 Reset, start_i=1 -> state_o 0 then 1 next cycle; all Write enables 1.
REQ-037 RUN, IDEX_MemRead_i=1, IDEX_RTaddr_i=5, IFID_RSaddr_i=5 -> PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1 one cycle; RTaddr 0 -> no stall.
REQ-038 RUN, EXMEM_MemReq_i=1, mem_ack_i after 3 cycles -> freeze 3 cycles, state_o=2 for cycles 2-3, RUN after ack; stall_cnt_o=3 with PERF_EN.
REQ-039 EXMEM_BranchTaken_i=1 with load-use hazard same cycle -> three Flush outputs 1, PCWrite_o=1 (branch wins).
REQ-040 WDOG_CYCLES=8, mem_ack_i held 0 -> HALT after 8 MEMWAIT cycles, err_o=1 until rst_i.
REQ-041 start_i dropped in RUN with one memory stall during DRAIN -> DRAIN lasts 4 advancing cycles plus the stall, then IDLE.
